// File: rtl/fb_fill_ctrl.sv
// fb_fill_ctrl: framebuffer pixel writer merging CPU single-pixel writes with a rectangle-fill engine.
// CPU writes always win the write port; the fill engine stalls in place for each CPU cycle.
module fb_fill_ctrl #(
    parameter int FB_W = 160,
    parameter int FB_H = 120
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic       cpu_we,
    input  logic [7:0] cpu_x,
    input  logic [6:0] cpu_y,
    input  logic [8:0] cpu_dt,
    input  logic       fill_start,
    input  logic [7:0] fill_x0,
    input  logic [6:0] fill_y0,
    input  logic [7:0] fill_x1,
    input  logic [6:0] fill_y1,
    input  logic [8:0] fill_color,
    output logic       fill_busy,
    output logic       fill_done,
    output logic [9:0] fb_wx,
    output logic [9:0] fb_wy,
    output logic [8:0] fb_dt,
    output logic       fb_sw
);
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
    state_t     state_q;
    logic [7:0] x0_q, x1_q, cx_q, x1_c;
    logic [6:0] y0_q, y1_q, cy_q, y1_c;
    logic [8:0] col_q;
    logic       cpu_ok, fill_pix, row_end, last_pix;
    assign x1_c     = (int'(x1_q) > FB_W - 1) ? 8'(FB_W - 1) : x1_q;
    assign y1_c     = (int'(y1_q) > FB_H - 1) ? 7'(FB_H - 1) : y1_q;
    assign cpu_ok   = cpu_we && (int'(cpu_x) < FB_W) && (int'(cpu_y) < FB_H);
    assign fill_pix = (state_q == FILL) && !cpu_we;
    assign row_end  = cx_q == x1_q;
    assign last_pix = row_end && (cy_q == y1_q);
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            col_q     <= '0;
            fb_wx     <= '0;
            fb_wy     <= '0;
            fb_dt     <= '0;
            fb_sw     <= 1'b0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            fb_sw     <= cpu_ok || fill_pix;
            fill_done <= state_q == DONE;
            if (cpu_ok) begin
                fb_wx <= {2'b00, cpu_x};
                fb_wy <= {3'b000, cpu_y};
                fb_dt <= cpu_dt;
            end else if (fill_pix) begin
                fb_wx <= {2'b00, cx_q};
                fb_wy <= {3'b000, cy_q};
                fb_dt <= col_q;
            end
            case (state_q)
                IDLE: if (fill_start) begin
                    x0_q      <= fill_x0;
                    y0_q      <= fill_y0;
                    x1_q      <= fill_x1;
                    y1_q      <= fill_y1;
                    col_q     <= fill_color;
                    state_q   <= SETUP;
                    fill_busy <= 1'b1;
                end
                SETUP: begin
                    x1_q <= x1_c;
                    y1_q <= y1_c;
                    if (x0_q > x1_c || y0_q > y1_c) begin
                        state_q   <= DONE;
                        fill_busy <= 1'b0;
                    end else begin
                        cx_q    <= x0_q;
                        cy_q    <= y0_q;
                        state_q <= FILL;
                    end
                end
                // a CPU cycle leaves cx/cy untouched so the same fill pixel is retried
                FILL: if (!cpu_we) begin
                    if (last_pix) begin
                        state_q   <= DONE;
                        fill_busy <= 1'b0;
                    end else if (row_end) begin
                        cx_q <= x0_q;
                        cy_q <= cy_q + 7'd1;
                    end else begin
                        cx_q <= cx_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_fill_ctrl.sv
// tb_fb_fill_ctrl: scoreboard bench for fb_fill_ctrl covering CPU writes, fills, contention, clamp and reset abort.
module tb_fb_fill_ctrl;
    logic       clk50 = 1'b0, rst = 1'b1, cpu_we = 1'b0, fill_start = 1'b0;
    logic [7:0] cpu_x = '0, fill_x0 = '0, fill_x1 = '0;
    logic [6:0] cpu_y = '0, fill_y0 = '0, fill_y1 = '0;
    logic [8:0] cpu_dt = '0, fill_color = '0;
    logic       fill_busy, fill_done, fb_sw;
    logic [9:0] fb_wx, fb_wy;
    logic [8:0] fb_dt;
    int n_tests = 0, n_fail = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
    int fill_cnt = 0, fill_first = -1, fill_last = -1, start_cyc = 0, n0 = 0;
    logic [28:0] cpu_q[$];
    logic [28:0] fill_q[$];

    always #5 clk50 = ~clk50;

    fb_fill_ctrl dut (
        .clk50(clk50), .rst(rst), .cpu_we(cpu_we), .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_dt(cpu_dt),
        .fill_start(fill_start), .fill_x0(fill_x0), .fill_y0(fill_y0), .fill_x1(fill_x1),
        .fill_y1(fill_y1), .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
        .fb_wx(fb_wx), .fb_wy(fb_wy), .fb_dt(fb_dt), .fb_sw(fb_sw)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [28:0] pix(input int x, input int y, input int c);
        return {10'(x), 10'(y), 9'(c)};
    endfunction

    always @(posedge clk50) begin
        cyc++;
        #1;
        if (cpu_we && cpu_x < 8'd160 && cpu_y < 7'd120) begin
            chk("cpu_sw", 32'(fb_sw), 32'd1);
            chk("cpu_q", 32'(cpu_q.size() > 0), 32'd1);
            if (cpu_q.size() > 0) chk("cpu_pix", 32'({fb_wx, fb_wy, fb_dt}), 32'(cpu_q.pop_front()));
        end else if (cpu_we) begin
            chk("cpu_drop", 32'(fb_sw), 32'd0);
        end else if (fb_sw) begin
            if (fill_q.size() == 0) chk("spurious_wr", 32'(fb_sw), 32'd0);
            else begin
                chk("fill_pix", 32'({fb_wx, fb_wy, fb_dt}), 32'(fill_q.pop_front()));
                fill_cnt++;
                if (fill_first < 0) fill_first = cyc;
                fill_last = cyc;
            end
        end
        if (fill_done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_busy", 32'(fill_busy), 32'd0);
        end
    end

    task automatic cpu_write(input int x, input int y, input int c);
        @(negedge clk50);
        cpu_we = 1'b1;
        cpu_x  = 8'(x);
        cpu_y  = 7'(y);
        cpu_dt = 9'(c);
        if (x < 160 && y < 120) cpu_q.push_back(pix(x, y, c));
        @(negedge clk50);
        cpu_we = 1'b0;
    endtask

    task automatic start_fill(input int x0, input int y0, input int x1, input int y1, input int c, input bit with_cpu);
        int cx1, cy1;
        cx1 = (x1 > 159) ? 159 : x1;
        cy1 = (y1 > 119) ? 119 : y1;
        @(negedge clk50);
        fill_start = 1'b1;
        fill_x0    = 8'(x0);
        fill_y0    = 7'(y0);
        fill_x1    = 8'(x1);
        fill_y1    = 7'(y1);
        fill_color = 9'(c);
        if (with_cpu) begin
            cpu_we = 1'b1;
            cpu_x  = 8'd100;
            cpu_y  = 7'd100;
            cpu_dt = 9'h155;
            cpu_q.push_back(pix(100, 100, 'h155));
        end
        start_cyc  = cyc + 1;
        fill_cnt   = 0;
        fill_first = -1;
        fill_last  = -1;
        for (int y = y0; y <= cy1; y++)
            for (int x = x0; x <= cx1; x++) fill_q.push_back(pix(x, y, c));
        @(negedge clk50);
        fill_start = 1'b0;
        cpu_we     = 1'b0;
    endtask

    task automatic check_fill(input string tag, input int n, input int extra);
        int d0, t;
        d0 = done_cnt;
        t  = 0;
        while (done_cnt == d0 && t < n + extra + 20) begin
            @(negedge clk50);
            t++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_cnt"}, 32'(fill_cnt), 32'(n));
        chk({tag, "_done_lat"}, 32'(done_cyc - start_cyc), 32'(n + 2 + extra));
        if (n > 0) begin
            chk({tag, "_first_lat"}, 32'(fill_first - start_cyc), 32'd2);
            chk({tag, "_last_lat"}, 32'(fill_last - start_cyc), 32'(n + 1 + extra));
        end
        chk({tag, "_q_left"}, 32'(fill_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk50);
        chk("rst_sw", 32'(fb_sw), 32'd0);
        chk("rst_wx", 32'(fb_wx), 32'd0);
        chk("rst_wy", 32'(fb_wy), 32'd0);
        chk("rst_dt", 32'(fb_dt), 32'd0);
        chk("rst_busy", 32'(fill_busy), 32'd0);
        chk("rst_done", 32'(fill_done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk50);
        cpu_write(10, 20, 'h1FF);
        @(posedge clk50);
        #1 chk("cpu_off", 32'(fb_sw), 32'd0);
        cpu_write(160, 5, 'h3);
        cpu_write(5, 120, 'h3);
        start_fill(2, 3, 4, 4, 'h0A5, 1'b0);
        check_fill("rect", 6, 0);
        start_fill(0, 0, 200, 0, 'h123, 1'b0);
        repeat (10) @(negedge clk50);
        cpu_write(1, 2, 'h11);
        repeat (7) @(negedge clk50);
        cpu_write(3, 4, 'h22);
        cpu_write(5, 6, 'h33);
        check_fill("clamp", 160, 3);
        start_fill(5, 5, 4, 5, 'h1, 1'b0);
        check_fill("degen", 0, 0);
        start_fill(7, 7, 7, 7, 'h77, 1'b1);
        check_fill("single", 1, 0);
        start_fill(0, 0, 9, 9, 'h1AA, 1'b0);
        repeat (5) @(negedge clk50);
        chk("busy_mid", 32'(fill_busy), 32'd1);
        fill_start = 1'b1;
        fill_x0    = 8'd50;
        fill_y0    = 7'd50;
        fill_x1    = 8'd60;
        fill_y1    = 7'd60;
        fill_color = 9'h0;
        @(negedge clk50);
        fill_start = 1'b0;
        check_fill("ignore", 100, 0);
        start_fill(0, 0, 159, 119, 'h0F0, 1'b0);
        check_fill("full", 19200, 0);
        start_fill(0, 0, 50, 50, 'h155, 1'b0);
        repeat (20) @(negedge clk50);
        chk("pre_rst_sw", 32'(fb_sw), 32'd1);
        n0  = done_cnt;
        rst = 1'b1;
        #1;
        chk("arst_sw", 32'(fb_sw), 32'd0);
        chk("arst_wx", 32'(fb_wx), 32'd0);
        chk("arst_wy", 32'(fb_wy), 32'd0);
        chk("arst_dt", 32'(fb_dt), 32'd0);
        chk("arst_busy", 32'(fill_busy), 32'd0);
        fill_q.delete();
        repeat (3) @(negedge clk50);
        rst = 1'b0;
        repeat (10) @(negedge clk50);
        chk("rst_no_done", 32'(done_cnt - n0), 32'd0);
        start_fill(1, 1, 3, 2, 'h0C3, 1'b0);
        check_fill("post_rst", 6, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_fill_ctrl.md
FB_FILL_CTRL -- requirements
Module: fb_fill_ctrl

Interface
REQ-001 Parameters SHALL be:
- FB_W, 160, framebuffer width in pixels.
- FB_H, 120, framebuffer height in pixels.
REQ-002 Ports SHALL be:
- clk50  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- cpu_we  in  1  CPU single-pixel write request, one pixel per high cycle.
- cpu_x  in  8  CPU pixel X.
- cpu_y  in  7  CPU pixel Y.
- cpu_dt  in  9  CPU pixel colour (RGB333).
- fill_start  in  1  start rectangle fill.
- fill_x0  in  8  fill left X.
- fill_y0  in  7  fill top Y.
- fill_x1  in  8  fill right X, inclusive.
- fill_y1  in  7  fill bottom Y, inclusive.
- fill_color  in  9  fill colour.
- fill_busy  out  1  high while fill is in SETUP or FILL.
- fill_done  out  1  one-cycle pulse when a fill finishes.
- fb_wx  out  10  framebuffer write X; bits [9:8] always 0.
- fb_wy  out  10  framebuffer write Y; bits [9:7] always 0.
- fb_dt  out  9  framebuffer write colour.
- fb_sw  out  1  framebuffer write strobe.

Function
REQ-003 The fb_* outputs SHALL all be registered; each cycle, at most one pixel SHALL be presented with fb_sw high.
REQ-004 CPU writes SHALL have absolute priority. cpu_we high at edge n with cpu_x<FB_W and cpu_y<FB_H SHALL give fb_sw=1 with that pixel's X, Y and colour in cycle n+1.
REQ-005 A CPU write with cpu_x>=FB_W or cpu_y>=FB_H SHALL be dropped: fb_sw=0 and no aliasing.
REQ-006 The FSM SHALL have the states IDLE, SETUP, FILL and DONE.
REQ-007 IDLE -> SETUP SHALL occur on fill_start=1. In this transition, the block SHALL latch fill_x0, fill_y0, fill_x1, fill_y1 and fill_color.
REQ-008 fill_start while not in IDLE SHALL be ignored, and the latched parameters SHALL be unchanged.
REQ-009 In SETUP (one cycle), the block SHALL:
- clamp x1 to min(x1, FB_W-1) and y1 to min(y1, FB_H-1);
- if x0>x1 or y0>y1 after clamping, go to DONE with no pixel written;
- otherwise load cx=x0, cy=y0 and go to FILL.
REQ-010 In FILL, on each cycle with cpu_we=0, the block SHALL present pixel (cx,cy,color) with fb_sw=1 on the following cycle. It SHALL then advance in raster order: cx+1; at cx==x1, cx=x0 and cy+1.
REQ-011 In FILL, on a cycle with cpu_we=1, the block SHALL serve the CPU pixel per REQ-004 and hold cx/cy unchanged. No fill pixel SHALL be skipped or duplicated.
REQ-012 After pixel (x1,y1) is issued, the FSM SHALL go to DONE. DONE SHALL last one cycle with fill_done=1, then return to IDLE.
REQ-013 Without CPU contention, a fill started at edge n SHALL produce its first fb_sw at cycle n+2 and its last at n+1+N, where N=(x1-x0+1)*(y1-y0+1). fill_done SHALL be high in cycle n+2+N.
REQ-014 fill_busy SHALL be 1 exactly in SETUP and FILL. fill_done SHALL never coincide with fill_busy.
REQ-015 x0==x1 and y0==y1 SHALL write exactly one pixel.
REQ-016 A rectangle covering the whole framebuffer SHALL write exactly 19200 pixels without counter overflow. Internal counters SHALL be at least 8 bits for X and 7 bits for Y.
REQ-017 fill_start at the same edge as cpu_we SHALL both start the fill and serve the CPU write.

Reset
REQ-018 rst=1 SHALL immediately (asynchronously) force:
- state IDLE;
- fb_sw=0, fb_wx=0, fb_wy=0, fb_dt=0;
- fill_busy=0, fill_done=0;
- latched parameters and cx/cy cleared.
REQ-019 Reset during FILL SHALL abort the fill with no further writes and no fill_done. The first fill_start after reset release SHALL be accepted normally.

Verification
REQ-020 CPU write: cpu_we=1, x=10, y=20, dt=0x1FF for one cycle -> next cycle fb_sw=1, fb_wx=10, fb_wy=20, fb_dt=0x1FF; the following cycle fb_sw=0.
REQ-021 Out-of-range CPU write: cpu_we=1, x=160, y=5 -> fb_sw stays 0.
REQ-022 Fill: fill_start with (2,3)-(4,4), color 0x0A5 -> 6 consecutive writes (2,3),(3,3),(4,3),(2,4),(3,4),(4,4); first at n+2; fill_done at n+8.
REQ-023 Contention and clamp, with fill (0,0)-(200,0):
- x1 is clamped to 159, giving exactly 160 fill writes;
- cpu_we pulses injected mid-fill appear in-line;
- no fill pixel is lost or repeated;
- fill_done is delayed by the number of CPU pulses.
REQ-024 Degenerate fill and restart:
- fill (5,5)-(4,5) -> zero writes, fill_done at n+2;
- fill_start while busy -> ignored;
- rst asserted mid-fill -> outputs 0 immediately, no fill_done;
- new fill after reset completes correctly.
